// File: rtl/core_pkg.sv
// core_pkg: opcode constants, JALR funct3 and mul/div handshake state shared by the hazard logic
package core_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_JALR    = 3'b000;
  typedef enum logic {RUN, MD_WAIT} md_state_t;
endpackage

// File: rtl/reg_use_decoder.sv
// reg_use_decoder: flags which source registers the ID instruction reads and whether it is a JALR
module reg_use_decoder
  import core_pkg::*;
#(
  parameter int INSTR_WIDTH  = 32,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                   uses_rs1_o,
  output logic                   uses_rs2_o,
  output logic                   is_jalr_o
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [FUNCT3_WIDTH-1:0] funct3;
  logic                    instr_unused;
  assign opcode       = instr_i[OPCODE_WIDTH-1:0];
  assign funct3       = instr_i[12 +: FUNCT3_WIDTH];
  assign instr_unused = ^{instr_i[INSTR_WIDTH-1:12+FUNCT3_WIDTH], instr_i[11:OPCODE_WIDTH]};
  // U-type and JAL read no register; only R-type, stores and branches read rs2
  always_comb begin
    uses_rs1_o = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    uses_rs2_o = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    is_jalr_o  = (opcode == OPC_JALR) && (funct3 == F3_JALR);
  end
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stalls/flushes for load-use, JALR-on-load, branch redirect and mul/div wait
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int REGFILE_LEN    = 6,
  parameter int INSTR_WIDTH    = 32,
  parameter int OPCODE_WIDTH   = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_WIDTH-1:0] instr_IF_ID,
  input  logic [REGFILE_LEN-1:0] rs1_IF_ID,
  input  logic [REGFILE_LEN-1:0] rs2_IF_ID,
  input  logic [REGFILE_LEN-1:0] rd_ID_EX,
  input  logic                   reg_write_ID_EX,
  input  logic                   mem_read_ID_EX,
  input  logic [REGFILE_LEN-1:0] rd_EX_MEM,
  input  logic                   mem_read_EX_MEM,
  input  logic                   branch_taken_EX,
  input  logic                   md_req_EX,
  input  logic                   md_done,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   flush_IF_ID,
  output logic                   flush_ID_EX,
  output logic                   flush_EX_MEM,
  output logic                   md_start
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] flush_events,
  output logic [PERF_CNT_WIDTH-1:0] md_cycles
`endif
);
  logic      uses_rs1, uses_rs2, is_jalr;
  logic      load_use, jalr_wait, md_active, md_freeze, hazard_stall;
  md_state_t state_q, state_d;

  reg_use_decoder #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .FUNCT3_WIDTH(FUNCT3_WIDTH)
  ) u_dec (
    .instr_i   (instr_IF_ID),
    .uses_rs1_o(uses_rs1),
    .uses_rs2_o(uses_rs2),
    .is_jalr_o (is_jalr)
  );

  // Hazard detection; a JALR needs rs1 in ID, so a load one or two ahead must drain first
  always_comb begin
    load_use  = mem_read_ID_EX && reg_write_ID_EX && (rd_ID_EX != '0) &&
                ((uses_rs1 && rd_ID_EX == rs1_IF_ID) || (uses_rs2 && rd_ID_EX == rs2_IF_ID));
    jalr_wait = is_jalr && (rs1_IF_ID != '0) &&
                ((mem_read_ID_EX && reg_write_ID_EX && rd_ID_EX == rs1_IF_ID) ||
                 (mem_read_EX_MEM && rd_EX_MEM == rs1_IF_ID));
  end

  // Action priority: mul/div activity, then branch redirect, then load stalls
  always_comb begin
    state_d      = (state_q == RUN) ? (md_req_EX ? MD_WAIT : RUN) : (md_done ? RUN : MD_WAIT);
    md_start     = (state_q == RUN) && md_req_EX;
    md_active    = (state_q == MD_WAIT) || md_req_EX;
    md_freeze    = md_start || ((state_q == MD_WAIT) && !md_done);
    hazard_stall = !md_active && !branch_taken_EX && (load_use || jalr_wait);
    pc_write     = !md_freeze && !hazard_stall;
    if_id_write  = !md_freeze && !hazard_stall;
    id_ex_write  = !md_freeze;
    flush_IF_ID  = !md_active && branch_taken_EX;
    flush_ID_EX  = !md_active && (branch_taken_EX || load_use || jalr_wait);
    flush_EX_MEM = md_freeze;
  end

  // Mul/div handshake state; reset always returns to RUN
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? RUN : state_d;
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_CNT_WIDTH-1:0] CNT_ONE = 1;
  logic [PERF_CNT_WIDTH-1:0] stall_cycles_q, flush_events_q, md_cycles_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign md_cycles    = md_cycles_q;
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      md_cycles_q    <= '0;
    end else begin
      if (!pc_write && !(&stall_cycles_q)) stall_cycles_q <= stall_cycles_q + CNT_ONE;
      if (flush_IF_ID && !(&flush_events_q)) flush_events_q <= flush_events_q + CNT_ONE;
      if ((state_q == MD_WAIT) && !(&md_cycles_q)) md_cycles_q <= md_cycles_q + CNT_ONE;
    end
  end
`else
  logic [PERF_CNT_WIDTH-1:0] perf_unused;
  assign perf_unused = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and random checks of the hazard controller against a rule-level model
module tb_hazard_control_unit;
  localparam int RL = 6;
  localparam int IW = 32;
  localparam int PW = 32;
  localparam logic [6:0] OP = 7'b0110011, ST = 7'b0100011, BR = 7'b1100011, JR = 7'b1100111;
  localparam logic [6:0] JL = 7'b1101111, LU = 7'b0110111, AU = 7'b0010111, LD = 7'b0000011;
  localparam logic [6:0] OI = 7'b0010011;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [IW-1:0] instr_IF_ID;
  logic [RL-1:0] rs1_IF_ID, rs2_IF_ID, rd_ID_EX, rd_EX_MEM;
  logic reg_write_ID_EX, mem_read_ID_EX, mem_read_EX_MEM, branch_taken_EX, md_req_EX, md_done;
  logic pc_write, if_id_write, id_ex_write, flush_IF_ID, flush_ID_EX, flush_EX_MEM, md_start;
`ifdef HAZARD_PERF_EN
  logic [PW-1:0] stall_cycles, flush_events, md_cycles;
`endif

  hazard_control_unit #(.REGFILE_LEN(RL), .INSTR_WIDTH(IW), .PERF_CNT_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_IF_ID(instr_IF_ID), .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .rd_ID_EX(rd_ID_EX), .reg_write_ID_EX(reg_write_ID_EX), .mem_read_ID_EX(mem_read_ID_EX),
    .rd_EX_MEM(rd_EX_MEM), .mem_read_EX_MEM(mem_read_EX_MEM), .branch_taken_EX(branch_taken_EX),
    .md_req_EX(md_req_EX), .md_done(md_done), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .md_start(md_start)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events), .md_cycles(md_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  bit   waiting = 0;
  int   m_stall = 0, m_flush = 0, m_md = 0;
  int   n_stall, n_flushx, n_start;
  logic [6:0] obs, exp_v;

  function automatic logic [IW-1:0] mk(logic [6:0] op, logic [2:0] f3);
    logic [IW-1:0] r;
    r = $urandom;
    r[6:0] = op;
    r[14:12] = f3;
    return r;
  endfunction

  // Expected {pc,if_id,id_ex,flush_if_id,flush_id_ex,flush_ex_mem,md_start} from the written rules
  function automatic logic [6:0] model();
    logic [6:0] op;
    bit u1, u2, jr, lu, jw;
    op = instr_IF_ID[6:0];
    u1 = !(op == LU || op == AU || op == JL);
    u2 = (op == OP || op == ST || op == BR);
    jr = (op == JR) && (instr_IF_ID[14:12] == 3'd0);
    lu = mem_read_ID_EX && reg_write_ID_EX && rd_ID_EX != 0 &&
         ((u1 && rd_ID_EX == rs1_IF_ID) || (u2 && rd_ID_EX == rs2_IF_ID));
    jw = jr && rs1_IF_ID != 0 && ((mem_read_ID_EX && reg_write_ID_EX && rd_ID_EX == rs1_IF_ID) ||
                                  (mem_read_EX_MEM && rd_EX_MEM == rs1_IF_ID));
    if (waiting) return md_done ? 7'b1110000 : 7'b0000010;
    if (md_req_EX) return 7'b0000011;
    if (branch_taken_EX) return 7'b1111100;
    if (lu || jw) return 7'b0010100;
    return 7'b1110000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drive(input logic [IW-1:0] ins, input int r1, input int r2, input int rdx, input bit rw,
                       input bit mr, input int rdm, input bit mrm, input bit br, input bit req, input bit dn);
    instr_IF_ID = ins; rs1_IF_ID = RL'(r1); rs2_IF_ID = RL'(r2); rd_ID_EX = RL'(rdx);
    reg_write_ID_EX = rw; mem_read_ID_EX = mr; rd_EX_MEM = RL'(rdm); mem_read_EX_MEM = mrm;
    branch_taken_EX = br; md_req_EX = req; md_done = dn;
  endtask

  // Inputs are set just after a falling edge; check, then let the rising edge advance the model
  task automatic step(input string tag);
    #1;
    obs = {pc_write, if_id_write, id_ex_write, flush_IF_ID, flush_ID_EX, flush_EX_MEM, md_start};
    exp_v = model();
    chk(tag, 32'(obs), 32'(exp_v));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_events", flush_events, m_flush);
    chk("md_cycles", md_cycles, m_md);
`endif
    n_stall += !pc_write;
    n_flushx += flush_EX_MEM;
    n_start += md_start;
    @(posedge clk);
    if (!rst_n) begin
      waiting = 0; m_stall = 0; m_flush = 0; m_md = 0;
    end else begin
      m_stall += !exp_v[6];
      m_flush += (!waiting && !md_req_EX && branch_taken_EX);
      m_md += waiting;
      waiting = waiting ? !md_done : md_req_EX;
    end
    @(negedge clk);
  endtask

  initial begin
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("reset");
    rst_n = 1'b1;
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("idle_outputs", 32'({pc_write, if_id_write, id_ex_write, flush_IF_ID, flush_ID_EX,
                                flush_EX_MEM, md_start}), 32'h70);
    @(negedge clk);
    // load x5 then add x6,x5,x1
    drive(mk(OP, 0), 5, 1, 5, 1, 1, 0, 0, 0, 0, 0); step("load_use");
    drive(mk(OP, 0), 5, 1, 0, 0, 0, 5, 1, 0, 0, 0); step("load_use_release");
    // load x5 directly ahead of jalr x0,0(x5): two stalls
    n_stall = 0;
    drive(mk(JR, 0), 5, 0, 5, 1, 1, 0, 0, 0, 0, 0); step("jalr_d1");
    drive(mk(JR, 0), 5, 0, 0, 0, 0, 5, 1, 0, 0, 0); step("jalr_d2");
    drive(mk(JR, 0), 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("jalr_d3");
    chk("jalr_direct_stalls", n_stall, 2);
    // one unrelated instruction between: one stall
    n_stall = 0;
    drive(mk(JR, 0), 5, 0, 7, 1, 0, 5, 1, 0, 0, 0); step("jalr_g1");
    drive(mk(JR, 0), 5, 0, 0, 0, 0, 7, 0, 0, 0, 0); step("jalr_g2");
    chk("jalr_gap_stalls", n_stall, 1);
    drive(mk(JR, 0), 5, 0, 5, 1, 0, 0, 0, 0, 0, 0); step("jalr_alu_fwd");
    drive(mk(LU, 0), 5, 5, 5, 1, 1, 0, 0, 0, 0, 0); step("lui_no_stall");
    drive(mk(OP, 0), 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); step("load_x0");
    // branch overrides load-use
    drive(mk(OP, 0), 5, 1, 5, 1, 1, 0, 0, 1, 0, 0); step("branch_over_lu");
`ifdef HAZARD_PERF_EN
    #1 chk("flush_events_one", flush_events, 1);
    @(negedge clk);
`endif
    // mul/div: start, 4 waiting cycles, release
    n_stall = 0; n_flushx = 0; n_start = 0;
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("md_start");
    for (int i = 0; i < 4; i++) step("md_wait");
    md_done = 1; step("md_release");
    chk("md_freeze_cycles", n_stall, 5);
    chk("md_flush_cycles", n_flushx, 5);
    chk("md_start_pulses", n_start, 1);
    // back-to-back op issues a fresh start, ignored md_done in RUN
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("md_b2b_start");
    md_done = 1; step("md_b2b_release");
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("md_done_in_run");
    // reset while waiting
    drive('0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("md_start_r");
    rst_n = 1'b0; md_req_EX = 0; step("md_wait_reset");
    rst_n = 1'b1; step("after_reset");
`ifdef HAZARD_PERF_EN
    chk("perf_cleared", stall_cycles | flush_events | md_cycles, 0);
`endif
    // random traffic with a small register pool to provoke matches
    for (int i = 0; i < 600; i++) begin
      logic [6:0] ops [9] = '{OP, ST, BR, JR, JL, LU, AU, LD, OI};
      drive(mk(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 1))), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      rst_n = $urandom_range(0, 39) != 0;
      step("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
